// File: rtl/fir_serial_rx_if.sv
// Parallel sample handshake between the serial receiver and the FIR tap delay line.
// The master drives the assembled sample and its valid flag; the slave returns ready.
interface fir_serial_rx_if #(
  parameter int W = 16
) ();
  logic [W-1:0] data_out;
  logic         valid_o;
  logic         ready_i;

  modport master (
    output data_out,
    output valid_o,
    input  ready_i
  );

  modport slave (
    input  data_out,
    input  valid_o,
    output ready_i
  );
endinterface

// File: rtl/fir_serial_rx.sv
// Bit-serial sample receiver: deserializes a sync-framed, strobed bit stream into W-bit
// words and holds each one on a valid/ready port until the FIR tap line takes it.
module fir_serial_rx #(
  parameter int W         = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             sdata_i,
  fir_serial_rx_if.master  out_if,
  output logic             overrun_o,
  output logic             frame_err_o
);
  localparam int CW = $clog2(W + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          r_state, w_state_next;
  logic [CW-1:0]   r_cnt, w_cnt_next;
  logic [W-1:0]    r_shift, w_shift_next;
  logic [W-1:0]    r_data;
  logic            r_valid;
  logic            r_overrun;
  logic            r_frame_err;

  logic [W-1:0]    w_first;
  logic [W-1:0]    w_ins;
  logic            w_done;
  logic            w_frame_err;

  // A fresh frame's first bit lands where W-1 further shifts carry it to its final slot.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_first = {{(W-1){1'b0}}, sdata_i};
      assign w_ins   = {r_shift[W-2:0], sdata_i};
    end else begin : g_lsb_first
      assign w_first = {sdata_i, {(W-1){1'b0}}};
      assign w_ins   = {sdata_i, r_shift[W-1:1]};
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_shift <= w_shift_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_shift_next = r_shift;
    w_done       = 1'b0;
    w_frame_err  = 1'b0;
    if (en_i) begin
      case (r_state)
        IDLE: begin
          if (sync_i) begin
            w_shift_next = w_first;
            w_cnt_next   = CW'(1);
            w_state_next = SHIFT;
          end
        end
        SHIFT: begin
          // Sync wins over completion: a sync on the W-th bit restarts the frame.
          if (sync_i) begin
            w_frame_err  = 1'b1;
            w_shift_next = w_first;
            w_cnt_next   = CW'(1);
          end else if (r_cnt == CW'(W - 1)) begin
            w_done       = 1'b1;
            w_shift_next = '0;
            w_cnt_next   = '0;
            w_state_next = IDLE;
          end else begin
            w_shift_next = w_ins;
            w_cnt_next   = r_cnt + CW'(1);
          end
        end
        default: begin
          w_state_next = IDLE;
          w_cnt_next   = '0;
          w_shift_next = '0;
        end
      endcase
    end
  end

  // Output holding register: a pending word is only replaced when it is consumed on the same edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_frame_err;
      if (w_done) begin
        if (!r_valid || out_if.ready_i) begin
          r_data  <= w_ins;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && out_if.ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_if.data_out = r_data;
  assign out_if.valid_o  = r_valid;
  assign overrun_o       = r_overrun;
  assign frame_err_o     = r_frame_err;
endmodule

// File: tb/tb_fir_serial_rx.sv
// Drives two receivers (MSB-first and LSB-first, W=8) with one shared serial stream and
// compares every cycle against a frame-level model built from a queue of received bits.
module tb_fir_serial_rx;
  logic clk = 1'b0;
  logic rst_n;
  logic en, sync, sd, rdy;
  logic ovr_m, ovr_l, ferr_m, ferr_l;

  int n_assert = 0;
  int n_fail   = 0;
  int ferr_seen = 0;

  fir_serial_rx_if #(.W(8)) if_m ();
  fir_serial_rx_if #(.W(8)) if_l ();
  assign if_m.ready_i = rdy;
  assign if_l.ready_i = rdy;

  fir_serial_rx #(.W(8), .MSB_FIRST(1'b1)) u_msb (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .sync_i(sync), .sdata_i(sd),
    .out_if(if_m), .overrun_o(ovr_m), .frame_err_o(ferr_m)
  );

  fir_serial_rx #(.W(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .sync_i(sync), .sdata_i(sd),
    .out_if(if_l), .overrun_o(ovr_l), .frame_err_o(ferr_l)
  );

  always #5 clk = ~clk;

  // Reference model: bits of the current frame in arrival order, plus the output holding state.
  int        q[$];
  logic      m_valid;
  logic [7:0] m_data_m, m_data_l;
  logic      m_ovr;
  logic      m_ferr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic [7:0] w_msb, w_lsb;
    logic done;
    done = 1'b0;
    w_msb = '0;
    w_lsb = '0;
    if (!rst_n) begin
      q.delete();
      m_valid = 1'b0; m_data_m = '0; m_data_l = '0; m_ovr = 1'b0; m_ferr = 1'b0;
      return;
    end
    m_ferr = 1'b0;
    if (en) begin
      if (sync) begin
        m_ferr = (q.size() > 0);
        q.delete();
        q.push_back(int'(sd));
      end else if (q.size() > 0) begin
        q.push_back(int'(sd));
        if (q.size() == 8) begin
          for (int i = 0; i < 8; i++) begin
            w_msb = w_msb * 2 + 8'(q[i]);
            w_lsb = w_lsb + 8'(q[i] << i);
          end
          done = 1'b1;
          q.delete();
        end
      end
    end
    if (done) begin
      if (!m_valid || rdy) begin
        m_data_m = w_msb;
        m_data_l = w_lsb;
        m_valid  = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic check_all();
    if (ferr_m === 1'b1) ferr_seen++;
    chk("valid_msb", 32'(if_m.valid_o), 32'(m_valid));
    chk("valid_lsb", 32'(if_l.valid_o), 32'(m_valid));
    chk("data_msb",  32'(if_m.data_out), 32'(m_data_m));
    chk("data_lsb",  32'(if_l.data_out), 32'(m_data_l));
    chk("ovr_msb",   32'(ovr_m), 32'(m_ovr));
    chk("ovr_lsb",   32'(ovr_l), 32'(m_ovr));
    chk("ferr_msb",  32'(ferr_m), 32'(m_ferr));
    chk("ferr_lsb",  32'(ferr_l), 32'(m_ferr));
  endtask

  task automatic tick(input logic e, input logic s, input logic b, input logic r);
    @(negedge clk);
    en = e; sync = s; sd = b; rdy = r;
    model_step();
    @(posedge clk);
    #1;
    check_all();
    $display("t=%0t en=%0b sync=%0b sd=%0b rdy=%0b | valid=%0b data_m=%02h data_l=%02h ovr=%0b ferr=%0b",
             $time, e, s, b, r, if_m.valid_o, if_m.data_out, if_l.data_out, ovr_m, ferr_m);
  endtask

  task automatic send_bits(input logic [7:0] w, input int n, input bit lsb, input int gap,
                           input logic r, input logic r_last);
    for (int i = 0; i < n; i++) begin
      tick(1'b1, (i == 0), lsb ? w[i] : w[7-i], (i == n-1) ? r_last : r);
      if (i != n-1) repeat (gap) tick(1'b0, 1'($urandom), 1'($urandom), r);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; en = 1'b0; sync = 1'b0;
    model_step();
    #1;
    check_all();
    repeat (3) tick(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    @(negedge clk);
    rst_n = 1'b1; en = 1'b0; sync = 1'b0;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] rw;
    int f0;
    rst_n = 1'b1; en = 1'b0; sync = 1'b0; sd = 1'b0; rdy = 1'b0;
    #2;

    // Reset: random strobes while held, release mid-cycle, no spurious valid.
    do_reset();
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    chk("reset_data", 32'(if_m.data_out), 32'h00);
    chk("reset_valid", 32'(if_m.valid_o), 32'h0);

    // Basic frame, strobe every cycle.
    send_bits(8'hA5, 8, 1'b0, 0, 1'b1, 1'b1);
    chk("basic_valid", 32'(if_m.valid_o), 32'h1);
    chk("basic_data", 32'(if_m.data_out), 32'hA5);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    chk("basic_drop", 32'(if_m.valid_o), 32'h0);

    // LSB-first with a strobe one cycle in three.
    send_bits(8'h3C, 8, 1'b1, 2, 1'b1, 1'b1);
    chk("lsb_data", 32'(if_l.data_out), 32'h3C);
    chk("lsb_valid", 32'(if_l.valid_o), 32'h1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);

    // Early sync: partial frame then a fresh 0x81 frame.
    f0 = ferr_seen;
    rw = 8'($urandom);
    send_bits(rw, 5, 1'b0, 0, 1'b1, 1'b1);
    send_bits(8'h81, 8, 1'b0, 0, 1'b1, 1'b1);
    chk("esync_data", 32'(if_m.data_out), 32'h81);
    chk("esync_pulses", 32'(ferr_seen - f0), 32'd1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);

    // Backpressure and overrun.
    send_bits(8'h11, 8, 1'b0, 0, 1'b0, 1'b0);
    chk("bp_first_ovr", 32'(ovr_m), 32'h0);
    send_bits(8'h22, 8, 1'b0, 0, 1'b0, 1'b0);
    chk("bp_data", 32'(if_m.data_out), 32'h11);
    chk("bp_valid", 32'(if_m.valid_o), 32'h1);
    chk("bp_ovr", 32'(ovr_m), 32'h1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    chk("bp_consume", 32'(if_m.valid_o), 32'h0);
    chk("bp_ovr_sticky", 32'(ovr_m), 32'h1);

    // Simultaneous consume and complete.
    do_reset();
    send_bits(8'h55, 8, 1'b0, 0, 1'b0, 1'b0);
    send_bits(8'h66, 8, 1'b0, 0, 1'b0, 1'b1);
    chk("simul_data", 32'(if_m.data_out), 32'h66);
    chk("simul_valid", 32'(if_m.valid_o), 32'h1);
    chk("simul_ovr", 32'(ovr_m), 32'h0);
    tick(1'b0, 1'b0, 1'b0, 1'b1);

    // Reset mid-frame: partial word lost, next frame clean.
    send_bits(8'($urandom), 4, 1'b0, 0, 1'b1, 1'b1);
    do_reset();
    chk("midrst_valid", 32'(if_m.valid_o), 32'h0);
    chk("midrst_ferr", 32'(ferr_m), 32'h0);
    rw = 8'($urandom);
    send_bits(rw, 8, 1'b0, 1, 1'b1, 1'b1);
    chk("midrst_data", 32'(if_m.data_out), 32'(rw));

    // Random traffic against the model.
    repeat (600) tick(1'($urandom), ($urandom % 10) == 0, 1'($urandom), ($urandom % 4) != 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
